control: RTL and testbench

CONTROL -- requirements
Module: control

---
 rtl/control.sv | 111 +++++++++++
 tb/tb_control.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/control.sv
// Single-cycle MIPS-style main decoder with registered outputs.
// Decode of opcode/func is captured on each rising edge; reset low forces a NOP.
module control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic       ALUSrc1,
  output logic       ALUSrc2,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Mem2Reg,
  output logic       BranchEq,
  output logic       BranchNeq,
  output logic [1:0] PCSrc
);

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSll = 3'b011;
  localparam logic [2:0] AluNor = 3'b100;
  localparam logic [2:0] AluSrl = 3'b101;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  typedef struct packed {
    logic       alu_src1;
    logic       alu_src2;
    logic [2:0] alu_control;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_read;
    logic       mem_write;
    logic       mem2reg;
    logic       branch_eq;
    logic       branch_neq;
    logic [1:0] pc_src;
  } ctrl_t;

  ctrl_t ctrl_d, ctrl_q;

  always_comb begin
    ctrl_d = '0;
    unique case (opcode)
      6'h00: begin
        unique case (func)
          6'h20: begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1; ctrl_d.alu_control = AluAdd; end
          6'h22: begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1; ctrl_d.alu_control = AluSub; end
          6'h24: begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1; ctrl_d.alu_control = AluAnd; end
          6'h25: begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1; ctrl_d.alu_control = AluOr;  end
          6'h27: begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1; ctrl_d.alu_control = AluNor; end
          6'h2A: begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1; ctrl_d.alu_control = AluSlt; end
          6'h00, 6'h02: begin
            // Shifts take operand A from the zero-extended shamt field.
            ctrl_d.reg_write   = 1'b1;
            ctrl_d.reg_dst     = 1'b1;
            ctrl_d.alu_src1    = 1'b1;
            ctrl_d.alu_control = (func == 6'h00) ? AluSll : AluSrl;
          end
          6'h08: begin ctrl_d.pc_src = 2'b10; ctrl_d.alu_control = AluAdd; end
          default: ctrl_d = '0;
        endcase
      end
      6'h23: begin
        ctrl_d.alu_src2    = 1'b1;
        ctrl_d.alu_control = AluAdd;
        ctrl_d.mem_read    = 1'b1;
        ctrl_d.mem2reg     = 1'b1;
        ctrl_d.reg_write   = 1'b1;
      end
      6'h2B: begin
        ctrl_d.alu_src2    = 1'b1;
        ctrl_d.alu_control = AluAdd;
        ctrl_d.mem_write   = 1'b1;
      end
      6'h04: begin ctrl_d.branch_eq  = 1'b1; ctrl_d.alu_control = AluSub; end
      6'h05: begin ctrl_d.branch_neq = 1'b1; ctrl_d.alu_control = AluSub; end
      6'h08: begin ctrl_d.alu_src2 = 1'b1; ctrl_d.reg_write = 1'b1; ctrl_d.alu_control = AluAdd; end
      6'h0A: begin ctrl_d.alu_src2 = 1'b1; ctrl_d.reg_write = 1'b1; ctrl_d.alu_control = AluSlt; end
      6'h0C: begin ctrl_d.alu_src2 = 1'b1; ctrl_d.reg_write = 1'b1; ctrl_d.alu_control = AluAnd; end
      6'h0D: begin ctrl_d.alu_src2 = 1'b1; ctrl_d.reg_write = 1'b1; ctrl_d.alu_control = AluOr;  end
      6'h02: ctrl_d.pc_src = 2'b01;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign ALUSrc1    = ctrl_q.alu_src1;
  assign ALUSrc2    = ctrl_q.alu_src2;
  assign ALUControl = ctrl_q.alu_control;
  assign RegWrite   = ctrl_q.reg_write;
  assign RegDst     = ctrl_q.reg_dst;
  assign MemRead    = ctrl_q.mem_read;
  assign MemWrite   = ctrl_q.mem_write;
  assign Mem2Reg    = ctrl_q.mem2reg;
  assign BranchEq   = ctrl_q.branch_eq;
  assign BranchNeq  = ctrl_q.branch_neq;
  assign PCSrc      = ctrl_q.pc_src;

endmodule

// File: tb/tb_control.sv
// Bench for control: directed checks then random instructions against a table-driven model.
module tb_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, func;
  logic       ALUSrc1, ALUSrc2, RegWrite, RegDst, MemRead, MemWrite, Mem2Reg;
  logic       BranchEq, BranchNeq;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;

  int tests = 0;
  int fails = 0;

  control dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .func      (func),
    .ALUSrc1   (ALUSrc1),
    .ALUSrc2   (ALUSrc2),
    .ALUControl(ALUControl),
    .RegWrite  (RegWrite),
    .RegDst    (RegDst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Mem2Reg   (Mem2Reg),
    .BranchEq  (BranchEq),
    .BranchNeq (BranchNeq),
    .PCSrc     (PCSrc)
  );

  always #5 clk = ~clk;

  // Observed bundle: {ALUSrc1, ALUSrc2, ALUControl, RegWrite, RegDst, MemRead, MemWrite,
  //                   Mem2Reg, BranchEq, BranchNeq, PCSrc}
  logic [13:0] obs;
  assign obs = {ALUSrc1, ALUSrc2, ALUControl, RegWrite, RegDst, MemRead, MemWrite,
                Mem2Reg, BranchEq, BranchNeq, PCSrc};

  logic [13:0] r_tbl[int];
  logic [13:0] i_tbl[int];
  logic [13:0] last_exp;

  function automatic logic [13:0] mk(input logic a1, input logic a2, input logic [2:0] alu,
                                     input logic rw, input logic rd, input logic mr,
                                     input logic mw, input logic m2r, input logic beq,
                                     input logic bne, input logic [1:0] pc);
    return {a1, a2, alu, rw, rd, mr, mw, m2r, beq, bne, pc};
  endfunction

  function automatic logic [13:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return r_tbl.exists(int'(fn)) ? r_tbl[int'(fn)] : 14'h0;
    return i_tbl.exists(int'(op)) ? i_tbl[int'(op)] : 14'h0;
  endfunction

  task automatic chk(input string tag, input logic [13:0] o, input logic [13:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Drive at negedge, sample 1 time unit after the next rising edge.
  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic [5:0] fn);
    @(negedge clk);
    reset = rst; opcode = op; func = fn;
    @(posedge clk);
    #1;
    last_exp = rst ? ref_decode(op, fn) : 14'h0;
    chk(tag, obs, last_exp);
    tests++;
    assert (!(BranchEq && BranchNeq) && !(MemRead && MemWrite)) else begin
      fails++;
      $error("FAIL %s_excl observed=%b expected=no conflicting pair", tag, obs);
    end
  endtask

  logic [5:0] ops[13];
  logic [5:0] fns[10];

  initial begin
    // Model built from the instruction list with field names, independent of RTL encoding.
    //            a1 a2 alu     rw rd mr mw m2 be bn pc
    r_tbl[32'h20] = mk(0, 0, 3'b010, 1, 1, 0, 0, 0, 0, 0, 2'b00);
    r_tbl[32'h22] = mk(0, 0, 3'b110, 1, 1, 0, 0, 0, 0, 0, 2'b00);
    r_tbl[32'h24] = mk(0, 0, 3'b000, 1, 1, 0, 0, 0, 0, 0, 2'b00);
    r_tbl[32'h25] = mk(0, 0, 3'b001, 1, 1, 0, 0, 0, 0, 0, 2'b00);
    r_tbl[32'h27] = mk(0, 0, 3'b100, 1, 1, 0, 0, 0, 0, 0, 2'b00);
    r_tbl[32'h2A] = mk(0, 0, 3'b111, 1, 1, 0, 0, 0, 0, 0, 2'b00);
    r_tbl[32'h00] = mk(1, 0, 3'b011, 1, 1, 0, 0, 0, 0, 0, 2'b00);
    r_tbl[32'h02] = mk(1, 0, 3'b101, 1, 1, 0, 0, 0, 0, 0, 2'b00);
    r_tbl[32'h08] = mk(0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 2'b10);
    i_tbl[32'h23] = mk(0, 1, 3'b010, 1, 0, 1, 0, 1, 0, 0, 2'b00);
    i_tbl[32'h2B] = mk(0, 1, 3'b010, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    i_tbl[32'h04] = mk(0, 0, 3'b110, 0, 0, 0, 0, 0, 1, 0, 2'b00);
    i_tbl[32'h05] = mk(0, 0, 3'b110, 0, 0, 0, 0, 0, 0, 1, 2'b00);
    i_tbl[32'h08] = mk(0, 1, 3'b010, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    i_tbl[32'h0A] = mk(0, 1, 3'b111, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    i_tbl[32'h0C] = mk(0, 1, 3'b000, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    i_tbl[32'h0D] = mk(0, 1, 3'b001, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    i_tbl[32'h02] = mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b01);

    ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C,
            6'h0D, 6'h02, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h08, 6'h3F};

    reset = 1'b0; opcode = 6'h00; func = 6'h20;

    // Reset dominates decode, and holds while low.
    step("reset_add", 1'b0, 6'h00, 6'h20);
    step("reset_lw", 1'b0, 6'h23, 6'h00);
    chk("reset_zero", obs, 14'h0);
    step("jr", 1'b1, 6'h00, 6'h08);
    chk("jr_direct", obs, mk(0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 2'b10));
    step("sub", 1'b1, 6'h00, 6'h22);
    chk("sub_direct", obs, mk(0, 0, 3'b110, 1, 1, 0, 0, 0, 0, 0, 2'b00));
    step("lw", 1'b1, 6'h23, 6'h15);
    step("bne", 1'b1, 6'h05, 6'h00);
    step("bad_op", 1'b1, 6'h3F, 6'h00);
    step("bad_func", 1'b1, 6'h00, 6'h01);
    step("sll", 1'b1, 6'h00, 6'h00);
    step("midreset", 1'b0, 6'h00, 6'h2A);
    step("after_reset", 1'b1, 6'h0D, 6'h00);

    // Inputs changed between edges must not disturb the registered outputs.
    @(negedge clk);
    opcode = 6'h2B; func = 6'h00;
    #2;
    chk("hold_between_edges", obs, last_exp);
    @(posedge clk);
    #1;
    chk("sw_after_edge", obs, ref_decode(6'h2B, 6'h00));
    last_exp = obs;

    for (int i = 0; i < 300; i++) begin
      logic [5:0] op, fn;
      logic       rst;
      op  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 12)];
      fn  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 9)];
      rst = ($urandom_range(0, 9) != 0);
      step("random", rst, op, fn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
